uart_receiver: RTL

// - Serial-to-parallel UART receiver; consumes the tx line of uart_transmitter (loopback) or an external rx pin.
// - Frame: 1 start (0), 8 data bits LSB first, optional even parity, 1 stop (1); idle line high.
// - Oversamples rx at CLKS_PER_BIT clocks per bit, samples mid-bit, presents byte with 1-cycle valid strobe.
// - Output feeds host-side logic / RX FIFO; no backpressure (consumer must take byte on valid).

---
 rtl/uart_receiver_if.sv | 24 ++
 rtl/uart_receiver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus host-side byte outputs of uart_receiver.
//   rx         serial input (idle high), driven by the line side
//   data       last received byte
//   valid      1-cycle strobe, good frame, data updated
//   frame_err  1-cycle strobe, stop bit sampled low
//   busy       receiver is inside a frame
//   parity_err 1-cycle strobe, even-parity mismatch (UART_RX_PARITY_EN only)
// Modports: master = receiver side, slave = line driver / host consumer side.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (input rx, output data, valid, frame_err, busy, parity_err);
  modport slave  (output rx, input data, valid, frame_err, busy, parity_err);
`else
  modport master (input rx, output data, valid, frame_err, busy);
  modport slave  (output rx, input data, valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver, 1 start, 8 data bits LSB first,
// optional even parity, 1 stop bit; idle line high. Bits are sampled at
// mid-bit; a received byte is presented with a 1-cycle valid strobe (no
// backpressure).
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, 11-bit frame
// and the parity_err output).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  uart_receiver_if.master: rx in; data, valid, frame_err, busy
//        (and parity_err) out
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  uart_receiver_if.master bus
);

  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = (H > 0) ? CW'(H - 1) : '0;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic          sync1;
  logic          sync2;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          perr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1   <= bus.rx;
      sync2   <= sync1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!sync2) begin
            cnt     <= '0;
            bit_idx <= '0;
            // With H == 0 the mid-start sample is this very edge, which
            // already saw a 0, so the start check is satisfied here.
            state   <= (H == 0) ? DATA : START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sync2) begin
              // Return at mid-stop so a back-to-back start edge is caught.
              data_q <= shift;
              state  <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift, par_bit}) perr_q  <= 1'b1;
              else                   valid_q <= 1'b1;
`else
              valid_q <= 1'b1;
`endif
            end else begin
              ferr_q <= 1'b1;
              state  <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A stuck-low line must go high before a new start is accepted.
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule
